beat_recorder_ctrl: RTL

BEAT_RECORDER_CTRL -- requirements
Module: beat_recorder_ctrl

---
 rtl/beat_recorder_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/beat_recorder_ctrl.sv
// Key-sequence recorder/player: records key changes into an external 256x7 RAM and
// replays them at one step per TICK_DIV clocks. Define BEAT_LOOP_PLAYBACK_EN for looped playback.
module beat_recorder_ctrl #(
   parameter int unsigned TICK_DIV = 50000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rec_start,
   input  logic       play_start,
   input  logic       stop,
   input  logic [6:0] ascii,
   input  logic [6:0] ram_rdata,
   output logic [7:0] ram_addr,
   output logic       ram_wren,
   output logic [6:0] ram_wdata,
   output logic [6:0] play_ascii,
   output logic       play_valid,
   output logic [1:0] state,
   output logic [7:0] length,
   output logic       full,
   output logic       done
);

   localparam int unsigned     DivW      = $clog2(TICK_DIV);
   localparam logic [DivW-1:0] DivReload = DivW'(TICK_DIV - 1);

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StRecord = 2'd1;
   localparam logic [1:0] StPlay   = 2'd2;

   logic [1:0]      state_q, state_d;
   logic [7:0]      rec_ptr_q, rec_ptr_d;
   logic [7:0]      length_q, length_d;
   logic            full_q, full_d;
   logic [6:0]      prev_ascii_q, prev_ascii_d;
   logic [8:0]      play_ptr_q, play_ptr_d;
   logic [DivW-1:0] div_q, div_d;
   logic            rd_pend_q, rd_pend_d;
   logic [6:0]      play_ascii_q, play_ascii_d;
   logic            play_valid_q, play_valid_d;
   logic            done_q, done_d;

   logic       key_new, wr_en, step, at_end;
   logic [8:0] eff_len;
   logic [7:0] rd_addr;

   // A full memory wraps length to 0, so the full flag supplies the ninth bit.
   assign eff_len = {full_q && (length_q == 8'd0), length_q};
   assign key_new = (state_q == StRecord) && (ascii != prev_ascii_q);
   assign wr_en   = key_new && (ascii != 7'd0) && !reset;
   assign step    = (state_q == StPlay) && (div_q == '0);
   assign at_end  = (play_ptr_q == eff_len);

`ifdef BEAT_LOOP_PLAYBACK_EN
   assign rd_addr = at_end ? 8'd0 : play_ptr_q[7:0];
`else
   assign rd_addr = play_ptr_q[7:0];
`endif

   always_comb begin
      state_d      = state_q;
      rec_ptr_d    = rec_ptr_q;
      length_d     = length_q;
      full_d       = full_q;
      prev_ascii_d = prev_ascii_q;
      play_ptr_d   = play_ptr_q;
      div_d        = div_q;
      rd_pend_d    = 1'b0;
      play_ascii_d = play_ascii_q;
      play_valid_d = 1'b0;
      done_d       = 1'b0;

      // An abort discards a read still in flight so play_ascii holds.
      if (rd_pend_q && !((state_q == StPlay) && stop)) begin
         play_ascii_d = ram_rdata;
         play_valid_d = 1'b1;
      end

      case (state_q)
         StIdle: begin
            if (rec_start) begin
               state_d      = StRecord;
               rec_ptr_d    = 8'd0;
               length_d     = 8'd0;
               full_d       = 1'b0;
               prev_ascii_d = 7'd0;
            end else if (play_start && (eff_len != 9'd0)) begin
               state_d    = StPlay;
               play_ptr_d = 9'd0;
               div_d      = '0;
            end
         end
         StRecord: begin
            if (key_new) prev_ascii_d = ascii;
            if (wr_en) begin
               rec_ptr_d = rec_ptr_q + 8'd1;
               length_d  = length_q + 8'd1;
               if (rec_ptr_q == 8'hff) begin
                  full_d  = 1'b1;
                  state_d = StIdle;
               end
            end
            if (stop) state_d = StIdle;
         end
         StPlay: begin
            if (stop) begin
               state_d = StIdle;
            end else if (step) begin
               div_d = DivReload;
               if (at_end) begin
                  done_d = 1'b1;
`ifdef BEAT_LOOP_PLAYBACK_EN
                  play_ptr_d = 9'd1;
                  rd_pend_d  = 1'b1;
`else
                  state_d = StIdle;
`endif
               end else begin
                  play_ptr_d = play_ptr_q + 9'd1;
                  rd_pend_d  = 1'b1;
               end
            end else begin
               div_d = div_q - 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         rec_ptr_q    <= 8'd0;
         length_q     <= 8'd0;
         full_q       <= 1'b0;
         prev_ascii_q <= 7'd0;
         play_ptr_q   <= 9'd0;
         div_q        <= '0;
         rd_pend_q    <= 1'b0;
         play_ascii_q <= 7'd0;
         play_valid_q <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         rec_ptr_q    <= rec_ptr_d;
         length_q     <= length_d;
         full_q       <= full_d;
         prev_ascii_q <= prev_ascii_d;
         play_ptr_q   <= play_ptr_d;
         div_q        <= div_d;
         rd_pend_q    <= rd_pend_d;
         play_ascii_q <= play_ascii_d;
         play_valid_q <= play_valid_d;
         done_q       <= done_d;
      end
   end

   assign ram_wren   = wr_en;
   assign ram_wdata  = wr_en ? ascii : 7'd0;
   assign ram_addr   = (state_q == StRecord) ? rec_ptr_q :
                       (state_q == StPlay)   ? rd_addr   : 8'd0;
   assign play_ascii = play_ascii_q;
   assign play_valid = play_valid_q;
   assign state      = state_q;
   assign length     = length_q;
   assign full       = full_q;
   assign done       = done_q;

endmodule
